ids_chi2_detector: RTL and testbench

- Parametrised chi-square intrusion detector for the per-interval edge-count stream.
- Training phase: builds a baseline histogram from the first POPSIZE samples.
- Detection phase: bins samples into tumbling frames of FRAME_SIZE and computes a Pearson statistic per frame with a sequential divider.
- Alarm output has K-frame hysteresis, runtime threshold, retrain control and an overrun flag.

---
 rtl/ids_chi2_detector.sv | 191 +++++++++++++++++++
 tb/tb_ids_chi2_detector.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ids_chi2_detector.sv
// Chi-square intrusion detector: trains a baseline histogram, then scores tumbling frames
// against it with a bit-serial divider and drives a hysteretic alarm.
module ids_chi2_detector #(
    parameter int DATA_WIDTH = 8,
    parameter int NBINS      = 6,
    parameter int BIN_SHIFT  = 3,
    parameter int BIN_BASE   = 4,
    parameter int POPSIZE    = 100,
    parameter int FRAME_SIZE = 20,
    parameter int STAT_W     = 32,
    parameter int ALARM_K    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_rdy,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  retrain,
    input  logic [STAT_W-1:0]     thresh,
    output logic                  trained,
    output logic                  stat_valid,
    output logic [STAT_W-1:0]     stat_out,
    output logic                  is_attacked,
    output logic                  overrun
);
    localparam int BIN_W = $clog2(NBINS);
    localparam int TW    = $clog2(POPSIZE + 1);
    localparam int OW    = $clog2(FRAME_SIZE + 1);
    localparam int DW    = $clog2(STAT_W);
    localparam int KW    = $clog2(ALARM_K + 1);

    typedef enum logic {TRAIN, DETECT} mode_t;
    typedef enum logic [2:0] {C_IDLE, C_SETUP, C_DIV, C_ACC, C_DONE} cstate_t;

    mode_t            mode;
    cstate_t          cstate;
    logic [TW-1:0]    t_hist [NBINS];
    logic [OW-1:0]    o_hist [NBINS];
    logic [OW-1:0]    o_snap [NBINS];
    logic [TW-1:0]    tcnt;
    logic [OW-1:0]    fcnt;
    logic [BIN_W-1:0] cb;
    logic [DW-1:0]    dcnt;
    logic [STAT_W:0]  rem;
    logic [STAT_W-1:0] quo;
    logic [STAT_W-1:0] sum;
    logic [KW-1:0]    acnt;

    logic [BIN_W-1:0]         bin;
    logic [TW-1:0]            t_cur;
    logic [OW-1:0]            o_cur;
    logic [STAT_W-1:0]        po;
    logic [STAT_W-1:0]        ft;
    logic signed [STAT_W-1:0] d;
    logic [STAT_W:0]          rem_sh;
    logic                     rem_ge;
    logic                     hi;

    function automatic logic [BIN_W-1:0] bin_of(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] idx;
        idx = x >> BIN_SHIFT;
        if (idx <= DATA_WIDTH'(BIN_BASE))
            return '0;
        else if (idx - DATA_WIDTH'(BIN_BASE) >= DATA_WIDTH'(NBINS - 1))
            return BIN_W'(NBINS - 1);
        else
            return BIN_W'(idx - DATA_WIDTH'(BIN_BASE));
    endfunction

    function automatic logic [STAT_W-1:0] sat_sq(input logic signed [STAT_W-1:0] x);
        logic signed [2*STAT_W-1:0] p;
        p = x * x;
        if (p[2*STAT_W-1:STAT_W] != '0)
            return '1;
        return p[STAT_W-1:0];
    endfunction

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [STAT_W-1:0] b);
        logic [STAT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[STAT_W] ? '1 : s[STAT_W-1:0];
    endfunction

    always_comb begin
        bin    = bin_of(data_in);
        t_cur  = t_hist[cb];
        o_cur  = o_snap[cb];
        po     = STAT_W'(POPSIZE) * STAT_W'(o_cur);
        ft     = STAT_W'(FRAME_SIZE) * STAT_W'(t_cur);
        d      = $signed(po - ft);
        rem_sh = {rem[STAT_W-1:0], quo[STAT_W-1]};
        rem_ge = (rem_sh >= (STAT_W + 1)'(t_cur));
        hi     = (sum > thresh);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode <= TRAIN;  cstate <= C_IDLE;
            tcnt <= '0;  fcnt <= '0;  cb <= '0;  dcnt <= '0;
            rem <= '0;  quo <= '0;  sum <= '0;  acnt <= '0;
            for (int i = 0; i < NBINS; i++) begin
                t_hist[i] <= '0;  o_hist[i] <= '0;  o_snap[i] <= '0;
            end
            trained <= 1'b0;  stat_valid <= 1'b0;  stat_out <= '0;
            is_attacked <= 1'b0;  overrun <= 1'b0;
        end else if (retrain) begin
            // stat_out deliberately keeps the last reported statistic
            mode <= TRAIN;  cstate <= C_IDLE;
            tcnt <= '0;  fcnt <= '0;  cb <= '0;  dcnt <= '0;  sum <= '0;  acnt <= '0;
            for (int i = 0; i < NBINS; i++) begin
                t_hist[i] <= '0;  o_hist[i] <= '0;
            end
            trained <= 1'b0;  stat_valid <= 1'b0;  is_attacked <= 1'b0;  overrun <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            case (cstate)
                C_SETUP: begin
                    quo    <= sat_sq(d);
                    rem    <= '0;
                    dcnt   <= '0;
                    cstate <= C_DIV;
                end
                C_DIV: begin
                    rem  <= rem_ge ? rem_sh - (STAT_W + 1)'(t_cur) : rem_sh;
                    quo  <= {quo[STAT_W-2:0], rem_ge};
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == DW'(STAT_W - 1))
                        cstate <= C_ACC;
                end
                C_ACC: begin
                    // an empty baseline bin cannot be divided by; treat any hit there as maximal evidence
                    if (t_cur == '0)
                        sum <= sat_add(sum, (o_cur == '0) ? '0 : '1);
                    else
                        sum <= sat_add(sum, quo);
                    if (cb == BIN_W'(NBINS - 1)) begin
                        cstate <= C_DONE;
                    end else begin
                        cb     <= cb + 1'b1;
                        cstate <= C_SETUP;
                    end
                end
                C_DONE: begin
                    stat_out   <= sum;
                    stat_valid <= 1'b1;
                    cstate     <= C_IDLE;
                    if (hi != is_attacked) begin
                        if (acnt == KW'(ALARM_K - 1)) begin
                            is_attacked <= ~is_attacked;
                            acnt        <= '0;
                        end else begin
                            acnt <= acnt + 1'b1;
                        end
                    end else begin
                        acnt <= '0;
                    end
                end
                default: ;
            endcase

            if (data_rdy) begin
                if (mode == TRAIN) begin
                    t_hist[bin] <= t_hist[bin] + 1'b1;
                    if (tcnt == TW'(POPSIZE - 1)) begin
                        tcnt    <= '0;
                        trained <= 1'b1;
                        mode    <= DETECT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end else if (fcnt == OW'(FRAME_SIZE - 1)) begin
                    fcnt <= '0;
                    for (int i = 0; i < NBINS; i++)
                        o_hist[i] <= '0;
                    if (cstate == C_IDLE) begin
                        for (int i = 0; i < NBINS; i++)
                            o_snap[i] <= o_hist[i] + OW'(bin == BIN_W'(i));
                        cb     <= '0;
                        sum    <= '0;
                        cstate <= C_SETUP;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    fcnt        <= fcnt + 1'b1;
                    o_hist[bin] <= o_hist[bin] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ids_chi2_detector.sv
// Directed bench for ids_chi2_detector: expected frame results are queued by the stimulus
// and checked by an independent monitor when stat_valid fires.
module tb_ids_chi2_detector;
    localparam int PER = 10;
    localparam int LAT = 205;

    logic        clk;
    logic        rst;
    logic        data_rdy;
    logic [7:0]  data_in;
    logic        retrain;
    logic [31:0] thresh;
    logic        trained;
    logic        stat_valid;
    logic [31:0] stat_out;
    logic        is_attacked;
    logic        overrun;

    ids_chi2_detector dut (
        .clk(clk), .rst(rst), .data_rdy(data_rdy), .data_in(data_in),
        .retrain(retrain), .thresh(thresh), .trained(trained),
        .stat_valid(stat_valid), .stat_out(stat_out),
        .is_attacked(is_attacked), .overrun(overrun)
    );

    typedef struct {
        logic [31:0] stat;
        logic        att;
        longint      at;
    } exp_t;

    exp_t   sb[$];
    exp_t   e;
    int     checks = 0;
    int     failures = 0;
    longint last_cap = 0;

    initial clk = 1'b0;
    always #(PER/2) clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every stat_valid must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && stat_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_stat_valid actual=%0d required=none", stat_out);
            end else begin
                e = sb.pop_front();
                chk("stat_out", 64'(stat_out), 64'(e.stat));
                chk("is_attacked", 64'(is_attacked), 64'(e.att));
                chk("stat_latency", 64'($time), 64'(e.at));
            end
        end
    end

    task automatic put(input logic [7:0] v);
        data_in  = v;
        data_rdy = 1'b1;
        @(posedge clk);
        last_cap = $time;
        #1;
        data_rdy = 1'b0;
    endtask

    task automatic put_n(input logic [7:0] v, input int n);
        repeat (n) put(v);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_frame(input logic [31:0] s, input logic a);
        exp_t x;
        x.stat = s;
        x.att  = a;
        x.at   = last_cap + LAT * PER + PER / 2;
        sb.push_back(x);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_retrain();
        retrain = 1'b1;
        @(posedge clk);
        #1;
        retrain = 1'b0;
    endtask

    logic [7:0]  vecs [5] = '{8'd39, 8'd40, 8'd71, 8'd72, 8'd255};
    logic [31:0] stats[5] = '{32'd360000, 32'd160000, 32'd226666, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        rst = 1'b1;  data_rdy = 1'b0;  data_in = '0;  retrain = 1'b0;  thresh = '1;
        #2;
        chk("reset_trained", 64'(trained), 64'd0);
        chk("reset_stat_valid", 64'(stat_valid), 64'd0);
        chk("reset_stat_out", 64'(stat_out), 64'd0);
        chk("reset_is_attacked", 64'(is_attacked), 64'd0);
        chk("reset_overrun", 64'(overrun), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Uniform baseline, identical frame
        put_n(8'd42, 99);
        chk("trained_before_last", 64'(trained), 64'd0);
        put(8'd42);
        chk("trained_after_pop", 64'(trained), 64'd1);
        put_n(8'd42, 20);
        expect_frame(32'd0, 1'b0);
        drain();

        // Two-bin baseline, alarm hysteresis
        do_retrain();
        thresh = 32'd9999;
        put_n(8'd42, 50);
        put_n(8'd50, 50);
        put_n(8'd42, 15);  put_n(8'd50, 5);
        expect_frame(32'd10000, 1'b0);
        drain();
        put_n(8'd42, 15);  put_n(8'd50, 5);
        expect_frame(32'd10000, 1'b1);
        drain();
        put_n(8'd42, 10);  put_n(8'd50, 10);
        expect_frame(32'd0, 1'b1);
        drain();
        put_n(8'd42, 10);  put_n(8'd50, 10);
        expect_frame(32'd0, 1'b0);
        drain();

        // Sample in an empty baseline bin saturates
        do_retrain();
        chk("retrain_is_attacked", 64'(is_attacked), 64'd0);
        thresh = '1;
        put_n(8'd42, 100);
        put(8'd200);
        put_n(8'd42, 19);
        expect_frame(32'hFFFF_FFFF, 1'b0);
        drain();

        // Back-to-back frames overrun the computation
        do_retrain();
        chk("retrain_holds_stat", 64'(stat_out), 64'hFFFF_FFFF);
        chk("retrain_trained", 64'(trained), 64'd0);
        put_n(8'd42, 100);
        for (int i = 1; i <= 40; i++) begin
            put(8'd42);
            if (i == 20) expect_frame(32'd0, 1'b0);
        end
        chk("overrun_set", 64'(overrun), 64'd1);
        drain();
        idle(10);
        chk("overrun_sticky", 64'(overrun), 64'd1);
        do_retrain();
        chk("overrun_cleared", 64'(overrun), 64'd0);
        chk("trained_cleared", 64'(trained), 64'd0);

        // Bin boundaries against baseline T = {10,20,30,25,15,0}
        put_n(8'd0, 10);  put_n(8'd40, 20);  put_n(8'd48, 30);
        put_n(8'd56, 25); put_n(8'd64, 15);
        for (int i = 0; i < 5; i++) begin
            put_n(vecs[i], 20);
            expect_frame(stats[i], 1'b0);
            drain();
        end

        // Asynchronous reset in the middle of a divide
        do_retrain();
        put_n(8'd42, 100);
        put_n(8'd42, 20);
        idle(50);
        #3;
        rst = 1'b1;
        #1;
        chk("async_trained", 64'(trained), 64'd0);
        chk("async_stat_out", 64'(stat_out), 64'd0);
        chk("async_stat_valid", 64'(stat_valid), 64'd0);
        chk("async_is_attacked", 64'(is_attacked), 64'd0);
        chk("async_overrun", 64'(overrun), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        put_n(8'd42, 99);
        chk("post_reset_untrained", 64'(trained), 64'd0);
        put(8'd42);
        chk("post_reset_trained", 64'(trained), 64'd1);
        idle(260);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(PER * 60000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
